// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: multi-cycle restoring divider that borrows the execute-stage
// ALU for its subtractions. One quotient bit per DIV cycle; the FSM issues
// A - B through the ALU operand/control port and consumes Result/CarryOut.
// Optional macro ALU_DIV_SIGNED_EN adds an i_signed input for signed division
// (magnitude conversion at load, sign correction when results are committed).
module alu_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             i_signed,
`endif
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_b_negate,
  output logic [1:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_carry_out,
  input  logic             i_alu_zero
);

  localparam int CW = $clog2(STEPS);
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_b_negate;
  logic [1:0]       r_alu_op;

  // The ALU Zero flag carries no information for restoring division.
  logic             w_unused;
  assign w_unused = i_alu_zero;

  // One restoring step: the partial remainder shifted left by one bit is
  // 33 bits wide; its top bit (hi) forces the subtract because the shifted
  // value then certainly exceeds any 32-bit divisor.
  logic             w_hi;
  logic             w_ge;
  logic [WIDTH-1:0] w_shift_r;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_load_d;

  assign w_hi      = r_r[WIDTH-1];
  assign w_ge      = w_hi | i_alu_carry_out;
  assign w_shift_r = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_r_next  = w_ge ? i_alu_result : w_shift_r;
  assign w_q_next  = {r_q[WIDTH-2:0], w_ge};

`ifdef ALU_DIV_SIGNED_EN
  // Signed mode: divide magnitudes, then fix the signs as results are
  // committed. The negations here are local; the ALU is never involved.
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_dd;
  logic w_neg_dv;

  assign w_neg_dd  = i_signed & i_dividend[WIDTH-1];
  assign w_neg_dv  = i_signed & i_divisor[WIDTH-1];
  assign w_load_q  = w_neg_dd ? (~i_dividend + 1'b1) : i_dividend;
  assign w_load_d  = w_neg_dv ? (~i_divisor + 1'b1) : i_divisor;
  assign w_q_final = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
  assign w_r_final = r_neg_r ? (~w_r_next + 1'b1) : w_r_next;

  // Latch the sign-correction flags when a divide is accepted.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_neg_q <= w_neg_dd ^ w_neg_dv;
      r_neg_r <= w_neg_dd;
    end
  end
`else
  assign w_load_q  = i_dividend;
  assign w_load_d  = i_divisor;
  assign w_q_final = w_q_next;
  assign w_r_final = w_r_next;
`endif

  // Sequencer FSM: all outputs, including the ALU drives, are registers so
  // nothing combinational loops from AluResult back into AluA/AluB.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_q            <= '0;
      r_r            <= '0;
      r_d            <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_quotient     <= '0;
      r_remainder    <= '0;
      r_div_by_zero  <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_b_negate <= 1'b0;
      r_alu_op       <= OP_AND;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_divisor != '0) begin
              r_q            <= w_load_q;
              r_r            <= '0;
              r_d            <= w_load_d;
              r_cnt          <= CW'(STEPS - 1);
              r_quotient     <= '0;
              r_remainder    <= '0;
              r_div_by_zero  <= 1'b0;
              // First step compares {0, Q[msb]} against the divisor.
              r_alu_a        <= {{(WIDTH-1){1'b0}}, w_load_q[WIDTH-1]};
              r_alu_b        <= w_load_d;
              r_alu_b_negate <= 1'b1;
              r_alu_op       <= OP_ADD;
              r_state        <= ST_DIV;
            end else begin
              // Divide by zero: answer directly, no ALU traffic.
              r_quotient    <= '1;
              r_remainder   <= i_dividend;
              r_div_by_zero <= 1'b1;
              r_state       <= ST_DONE;
            end
          end
        end

        ST_DIV: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            // Last step: commit results so they are valid alongside Done.
            r_quotient     <= w_q_final;
            r_remainder    <= w_r_final;
            r_done         <= 1'b1;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_b_negate <= 1'b0;
            r_alu_op       <= OP_AND;
            r_state        <= ST_DONE;
          end else begin
            r_alu_a <= {w_r_next[WIDTH-2:0], w_q_next[WIDTH-1]};
          end
        end

        ST_DONE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            // Entered straight from IDLE on divide-by-zero: pulse Done now.
            r_done <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_quotient     = r_quotient;
  assign o_remainder    = r_remainder;
  assign o_div_by_zero  = r_div_by_zero;
  assign o_alu_a        = r_alu_a;
  assign o_alu_b        = r_alu_b;
  assign o_alu_b_negate = r_alu_b_negate;
  assign o_alu_op       = r_alu_op;

endmodule
